// File: rtl/demux_1_2_stream_pkg.sv
// ---------------------------------------------------------------------------
// demux_1_2_stream_pkg
//   Definitions shared by the 1:2 stream demux and its channel FIFOs.
//   - CH0 / CH1 : values of in_sel that route a beat to out0 / out1.
//   - cnt_w()   : width of a FIFO occupancy count for a given depth. The
//                 count must also represent the value DEPTH itself, so it
//                 is one bit wider than a pointer.
// ---------------------------------------------------------------------------
package demux_1_2_stream_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : demux_1_2_stream_pkg

// File: rtl/fifo_sync_fwft.sv
// ---------------------------------------------------------------------------
// fifo_sync_fwft
//   Single-clock first-word-fall-through FIFO. The head entry is presented
//   on rd_data as soon as it is stored; rd_en consumes it.
//
//   Parameters
//     DATA_W : entry width in bits
//     DEPTH  : number of entries, power of two and at least 2
//
//   Ports
//     clk, rst_n : clock, asynchronous active-low reset
//     wr_en      : write wr_data this cycle (ignored while full)
//     wr_data    : entry to write
//     rd_en      : consume the head entry this cycle (ignored while empty)
//     rd_data    : head entry (raw storage, meaningful only when !empty)
//     empty      : no entries held
//     full       : DEPTH entries held
//     count      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fifo_sync_fwft
  import demux_1_2_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      empty,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              push;
  logic              pop;

  // Guarding here as well as at the caller keeps the FIFO safe on its own:
  // an overflowing write or an underflowing read is simply dropped.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign count   = cnt_q;
  assign rd_data = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      // Pointers are exactly PTR_W bits, so the increment wraps modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;  // idle, or push and pop cancel out
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever observed
  // after it has been written, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule : fifo_sync_fwft

// File: rtl/demux_1_2_stream.sv
// ---------------------------------------------------------------------------
// demux_1_2_stream
//   Splits one valid/ready stream into two. Each beat carries a select bit
//   naming its destination channel; each channel buffers beats in its own
//   FWFT FIFO, so a stalled consumer only blocks beats headed its way.
//   Ordering is preserved within each channel.
//
//   Parameters
//     DATA_W : payload width in bits
//     DEPTH  : entries per channel FIFO, power of two and at least 2
//
//   Ports
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_data/in_sel        : input payload and destination (0 -> out0)
//     in_valid/in_ready     : input handshake
//     outN_data/outN_valid  : channel N head entry (data is 0 when invalid)
//     outN_ready            : channel N consumer accepts the head
//     outN_count            : channel N FIFO occupancy
// ---------------------------------------------------------------------------
module demux_1_2_stream
  import demux_1_2_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out0_data,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [DATA_W-1:0]        out1_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [cnt_w(DEPTH)-1:0]  out0_count,
  output logic [cnt_w(DEPTH)-1:0]  out1_count
);

  logic              full0, full1;
  logic              empty0, empty1;
  logic [DATA_W-1:0] head0, head1;
  logic              sel_full;
  logic              accept;
  logic              push0, push1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    sel_full = full0;
    push0    = 1'b0;
    push1    = 1'b0;
    if (in_sel == CH1) sel_full = full1;
    // Readiness depends only on the selected FIFO's current fullness; a pop
    // in the same cycle does not open a slot until the next cycle.
    in_ready = rst_n && !sel_full;
    accept   = in_valid && in_ready;
    if (in_sel == CH0) push0 = accept;
    else               push1 = accept;
  end

  fifo_sync_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push0),
    .wr_data (in_data),
    .rd_en   (out0_ready),
    .rd_data (head0),
    .empty   (empty0),
    .full    (full0),
    .count   (out0_count)
  );

  fifo_sync_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push1),
    .wr_data (in_data),
    .rd_en   (out1_ready),
    .rd_data (head1),
    .empty   (empty1),
    .full    (full1),
    .count   (out1_count)
  );

  // Storage is unreset, so the head is masked to keep stale or unknown
  // contents off the output when the channel is empty.
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign out0_data  = out0_valid ? head0 : '0;
  assign out1_data  = out1_valid ? head1 : '0;

endmodule : demux_1_2_stream

// File: tb/tb_demux_1_2_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_1_2_stream
//   Self-checking bench for demux_1_2_stream (DATA_W=8, DEPTH=2): reset
//   state, a directed vector table, randomized traffic against a queue-based
//   reference model, and reset asserted with both channels holding data.
// ---------------------------------------------------------------------------
module tb_demux_1_2_stream;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out0_data, out1_data;
  logic              out0_valid, out1_valid;
  logic              out0_ready, out1_ready;
  logic [1:0]        out0_count, out1_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per channel, front = head entry.
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  demux_1_2_stream #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       valid;
    logic [7:0] data;
    logic       r0;
    logic       r1;
    logic       e_ir;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic [1:0] e_c0;
    logic [1:0] e_c1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sel, input logic valid, input logic [7:0] data,
                              input logic r0, input logic r1, input logic e_ir,
                              input logic e_v0, input logic [7:0] e_d0,
                              input logic e_v1, input logic [7:0] e_d1,
                              input logic [1:0] e_c0, input logic [1:0] e_c1);
    vec_t v;
    v.sel = sel;   v.valid = valid; v.data = data; v.r0 = r0; v.r1 = r1;
    v.e_ir = e_ir; v.e_v0 = e_v0;   v.e_d0 = e_d0; v.e_v1 = e_v1; v.e_d1 = e_d1;
    v.e_c0 = e_c0; v.e_c1 = e_c1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sel, input logic valid, input logic [7:0] data,
                       input logic r0, input logic r1);
    in_sel     = sel;
    in_valid   = valid;
    in_data    = data;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // One model-checked cycle: drive at the falling edge, compare 1 time unit
  // later, then let the rising edge happen and advance the model.
  task automatic step(input logic sel, input logic valid, input logic [7:0] data,
                      input logic r0, input logic r1, input string tag);
    logic       e_ir;
    logic       do_pop0, do_pop1;
    logic [7:0] e_d0, e_d1;
    @(negedge clk);
    drive(sel, valid, data, r0, r1);
    #1;
    e_ir = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    e_d0 = (q0.size() != 0) ? q0[0] : 8'h00;
    e_d1 = (q1.size() != 0) ? q1[0] : 8'h00;
    check({tag, "_in_ready"}, 32'(in_ready),   32'(e_ir));
    check({tag, "_v0"},       32'(out0_valid), 32'(q0.size() != 0));
    check({tag, "_v1"},       32'(out1_valid), 32'(q1.size() != 0));
    check({tag, "_d0"},       32'(out0_data),  32'(e_d0));
    check({tag, "_d1"},       32'(out1_data),  32'(e_d1));
    check({tag, "_c0"},       32'(out0_count), 32'(q0.size()));
    check({tag, "_c1"},       32'(out1_count), 32'(q1.size()));
    do_pop0 = r0 && (q0.size() != 0);
    do_pop1 = r1 && (q1.size() != 0);
    @(posedge clk);
    if (do_pop0) void'(q0.pop_front());
    if (do_pop1) void'(q1.pop_front());
    if (valid && e_ir) begin
      if (sel) q1.push_back(data);
      else     q0.push_back(data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // ---------------- reset state ----------------
    @(negedge clk);
    #1;
    check("rst_in_ready_sel0", 32'(in_ready),   32'd0);
    check("rst_v0",            32'(out0_valid), 32'd0);
    check("rst_v1",            32'(out1_valid), 32'd0);
    check("rst_d0",            32'(out0_data),  32'd0);
    check("rst_d1",            32'(out1_data),  32'd0);
    check("rst_c0",            32'(out0_count), 32'd0);
    check("rst_c1",            32'(out1_count), 32'd0);
    in_sel = 1'b1;
    #1;
    check("rst_in_ready_sel1", 32'(in_ready),   32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    in_sel = 1'b0;
    #1;
    check("post_rst_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    check("post_rst_ready_sel1", 32'(in_ready), 32'd1);

    // ---------------- directed vector table ----------------
    // Each row: inputs driven before a rising edge, and the outputs expected
    // while those inputs are applied (i.e. state left by the previous rows).
    //            sel   vld   data   r0    r1    ir    v0    d0     v1    d1     c0    c1
    // Two beats to opposite channels, both consumers ready.
    vecs.push_back(mk(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 2'd1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 2'd0, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0));
    // Fill channel 0 while stalled; channel 1 still accepts.
    vecs.push_back(mk(1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h00, 2'd1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 8'h00, 2'd2, 2'd0));
    vecs.push_back(mk(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h00, 2'd2, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 8'hB0, 2'd2, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 8'hB0, 2'd1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0));
    // Channel 0 full: same-cycle pop does not admit a push (no bypass).
    vecs.push_back(mk(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC0, 1'b0, 8'h00, 2'd1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hC2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b0, 8'h00, 2'd2, 2'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b0, 8'h00, 2'd1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, 8'h00, 2'd2, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC2, 1'b0, 8'h00, 2'd1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0));
    // Channel 1 one-deep: push 0x05 and pop together, count holds at 1.
    vecs.push_back(mk(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 2'd0, 2'd1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 2'd0, 2'd1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 2'd0, 2'd1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].r0, vecs[i].r1);
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready),   32'(vecs[i].e_ir));
      check($sformatf("vec%0d_v0", i),       32'(out0_valid), 32'(vecs[i].e_v0));
      check($sformatf("vec%0d_d0", i),       32'(out0_data),  32'(vecs[i].e_d0));
      check($sformatf("vec%0d_v1", i),       32'(out1_valid), 32'(vecs[i].e_v1));
      check($sformatf("vec%0d_d1", i),       32'(out1_data),  32'(vecs[i].e_d1));
      check($sformatf("vec%0d_c0", i),       32'(out0_count), 32'(vecs[i].e_c0));
      check($sformatf("vec%0d_c1", i),       32'(out1_count), 32'(vecs[i].e_c1));
    end

    // ---------------- randomized traffic vs. queue model ----------------
    // Both FIFOs are empty here, matching the empty model queues.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom), ($urandom_range(0, 9) < 7), 8'($urandom),
           ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 5), "rnd");
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "drain");
    end
    check("drain_model_q0_empty", 32'(q0.size()), 32'd0);
    check("drain_model_q1_empty", 32'(q1.size()), 32'd0);

    // ---------------- reset with both channels holding two beats ----------------
    step(1'b0, 1'b1, 8'h31, 1'b0, 1'b0, "fill");
    step(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, "fill");
    step(1'b0, 1'b1, 8'h32, 1'b0, 1'b0, "fill");
    step(1'b1, 1'b1, 8'h42, 1'b0, 1'b0, "fill");
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("pre_rst_c0", 32'(out0_count), 32'd2);
    check("pre_rst_c1", 32'(out1_count), 32'd2);
    #1;
    rst_n = 1'b0;  // mid-cycle, well away from any clock edge
    #1;
    check("mid_rst_in_ready", 32'(in_ready),   32'd0);
    check("mid_rst_v0",       32'(out0_valid), 32'd0);
    check("mid_rst_v1",       32'(out1_valid), 32'd0);
    check("mid_rst_d0",       32'(out0_data),  32'd0);
    check("mid_rst_d1",       32'(out1_data),  32'd0);
    check("mid_rst_c0",       32'(out0_count), 32'd0);
    check("mid_rst_c1",       32'(out1_count), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    check("rel_ready_sel1", 32'(in_ready), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "after_rst");
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demux_1_2_stream
